twiddle_gen: RTL
================

TWIDDLE_GEN -- requirements
Module: twiddle_gen

Interface
REQ-001 SHALL have parameter W, default 16, meaning twiddle word width, signed Q2.(W-2), so 1.0 = 2^(W-2).
REQ-002 SHALL have parameter NPT, default 32, meaning FFT size; power of two, 8..1024; LOG2N = log2(NPT).
REQ-003 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit: request one stage sequence.
REQ-006 SHALL have port stage, input, ceil(log2(LOG2N)) bits: DIT stage number, sampled with start.
REQ-007 SHALL have port tw_ready, input, 1 bit: consumer accepts the current twiddle.
REQ-008 SHALL have port tw_valid, output, 1 bit: tw_re, tw_im and tw_k are valid.
REQ-009 SHALL have port tw_re, output, W bits: round(cos(2*pi*k/NPT) * 2^(W-2)).
REQ-010 SHALL have port tw_im, output, W bits: round(-sin(2*pi*k/NPT) * 2^(W-2)).
REQ-011 SHALL have port tw_k, output, LOG2N-1 bits: exponent k of the current twiddle.
REQ-012 SHALL have port tw_last, output, 1 bit: current twiddle is the final one of the sequence.
REQ-013 SHALL have port busy, output, 1 bit: a sequence is in progress.
REQ-014 SHALL have port err, output, 1 bit: one-cycle pulse when start is rejected.

Function
REQ-015 SHALL use two states: IDLE and RUN.
REQ-016 SHALL move from IDLE to RUN on start with stage < LOG2N, latch stage, and clear butterfly counter j to 0.
REQ-017 SHALL stay in IDLE and pulse err for one cycle on start with stage >= LOG2N.
REQ-018 SHALL ignore start while in RUN, with no err pulse.
REQ-019 SHALL emit NPT/2 twiddles per sequence, with j = 0..NPT/2-1 and k = (j mod 2^stage) * (NPT >> (stage+1)).
REQ-020 SHALL treat the output register as a free slot when tw_valid=0 or tw_ready=1; in RUN, when the slot is free and j < NPT/2, it SHALL load twiddle(k(j)) and set tw_valid=1, then increment j.
REQ-021 SHALL assert the first tw_valid one cycle after the accepted start, and sustain 1 twiddle/cycle while tw_ready=1.
REQ-022 SHALL hold tw_re, tw_im, tw_k and tw_last stable while tw_valid=1 and tw_ready=0.
REQ-023 SHALL assert tw_last with the output for j = NPT/2-1.
REQ-024 SHALL go RUN to IDLE, clear tw_valid and tw_last, and deassert busy in the cycle after the tw_last handshake; a start in that handshake cycle SHALL be ignored.
REQ-025 SHALL assert busy exactly while in RUN.
REQ-026 SHALL derive values from a quarter-wave cosine table of NPT/4+1 entries via octant/quadrant symmetry (k in 0..NPT/2-1 covers quadrants 0 and 1); the output SHALL be bit-identical to direct rounding.
REQ-027 SHALL never overflow: cos(0) = +2^(W-2) and -sin(pi/2) = -2^(W-2).

Reset
REQ-028 SHALL, on rst asserted, go asynchronously to IDLE with j=0 and all outputs (tw_valid, tw_re, tw_im, tw_k, tw_last, busy, err) = 0.
REQ-029 SHALL abort a sequence on reset mid-RUN with no further outputs; after release, the first output SHALL require a new start.

Structure
REQ-030 SHALL place W and NPT defaults, LOG2N, and the constant function that builds the rounded quarter-wave table in shared package twiddle_pkg.
REQ-031 SHALL implement the table plus symmetry mapping (k to tw_re/tw_im, registered) as sub-module twiddle_qrom; sequencing, handshake and counter SHALL stay in twiddle_gen.

Verification (NPT=32, W=16)
REQ-032 SHALL test: start, stage=0, tw_ready=1 -> 16 outputs k=0, tw_re=16384, tw_im=0, tw_last on the 16th, busy low afterwards.
REQ-033 SHALL test: start, stage=4 -> k=0..15; k=4 gives (11585,-11585); k=8 gives (0,-16384); k=12 gives (-11585,-11585).
REQ-034 SHALL test: start, stage=2 -> k sequence 0,4,8,12 repeated 4 times.
REQ-035 SHALL test: tw_ready toggled randomly with stage=3 -> no dropped or duplicated k, and outputs stable while stalled.
REQ-036 SHALL test: start with stage=5 -> err=1 for one cycle, busy stays 0; start during RUN is ignored.
REQ-037 SHALL test: rst asserted after the 5th output of stage=4 -> all outputs 0 immediately; a new start restarts at k=0.

Source files
------------

// File: rtl/twiddle_pkg.sv
// rtl/twiddle_pkg.sv - shared defaults, FSM state type and quarter-wave cosine table builder
package twiddle_pkg;

  localparam int W_DEF   = 16;
  localparam int NPT_DEF = 32;
  localparam int LOG2N   = $clog2(NPT_DEF);

  // pi in unsigned Q4.60; the fraction digits are the well-known hex expansion of pi
  localparam logic [63:0] PI_Q60 = 64'h3243F6A8885A308D;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Rounded entry i of the quarter-wave cosine table for an npt-point FFT:
  // round(cos(2*pi*i/npt) * 2^(w-2)) for i in 0..npt/4. Evaluated at elaboration
  // with a Q60 Taylor series so no real-number support is needed anywhere.
  function automatic logic [63:0] quarter_cos(input int i, input int npt, input int w);
    logic [127:0]        theta;
    logic [127:0]        theta2;
    logic [127:0]        term;
    logic signed [127:0] acc;
    theta  = ({64'd0, PI_Q60} * 128'(i)) / 128'(npt / 2);
    theta2 = (theta * theta) >> 60;
    term   = 128'd1 << 60;
    acc    = 128'sd1 <<< 60;
    for (int n = 1; n <= 12; n++) begin
      term = (term * theta2) >> 60;
      term = term / 128'((2 * n - 1) * (2 * n));
      if ((n % 2) == 1) acc = acc - signed'(term);
      else              acc = acc + signed'(term);
    end
    // round half up; the true value is never negative so a tiny negative residue rounds to 0
    acc = acc + (128'sd1 <<< (59 - (w - 2)));
    acc = acc >>> (60 - (w - 2));
    return acc[63:0];
  endfunction

endpackage

// File: rtl/twiddle_gen_qrom.sv
// rtl/twiddle_gen_qrom.sv - quarter-wave cosine table with quadrant mapping to registered tw_re/tw_im
module twiddle_qrom
  import twiddle_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int NPT = NPT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [$clog2(NPT)-2:0]    k,
  output logic [W-1:0]              re,
  output logic [W-1:0]              im
);

  localparam int KW = $clog2(NPT) - 1;
  localparam int Q  = NPT / 4;
  localparam logic [KW-1:0] Q_IDX = (KW)'(Q);

  logic [W-1:0]  rom [0:Q];
  logic          quad;
  logic [KW-1:0] idx_a;
  logic [KW-1:0] idx_b;
  logic [W-1:0]  val_a;
  logic [W-1:0]  val_b;
  logic [W-1:0]  re_d;
  logic [W-1:0]  im_d;

  for (genvar g = 0; g <= Q; g++) begin : g_rom
    localparam logic [63:0] ENTRY = quarter_cos(g, NPT, W);
    assign rom[g] = ENTRY[W-1:0];
  end

  // k = quad*Q + m: quadrant 0 gives (C[m], -C[Q-m]), quadrant 1 gives (-C[Q-m], -C[m])
  always_comb begin
    quad  = k[KW-1];
    idx_a = {1'b0, k[KW-2:0]};
    idx_b = Q_IDX - idx_a;
    val_a = rom[idx_a];
    val_b = rom[idx_b];
    re_d  = quad ? ((W)'(0) - val_b) : val_a;
    im_d  = quad ? ((W)'(0) - val_a) : ((W)'(0) - val_b);
  end

  // Output register: captures the mapped pair only when the sequencer loads a new twiddle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      re <= '0;
      im <= '0;
    end else if (load) begin
      re <= re_d;
      im <= im_d;
    end
  end

endmodule

// File: rtl/twiddle_gen.sv
// rtl/twiddle_gen.sv - per-stage DIT twiddle sequencer with valid/ready output slot
module twiddle_gen
  import twiddle_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int NPT = NPT_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [$clog2($clog2(NPT))-1:0] stage,
  input  logic                           tw_ready,
  output logic                           tw_valid,
  output logic [W-1:0]                   tw_re,
  output logic [W-1:0]                   tw_im,
  output logic [$clog2(NPT)-2:0]         tw_k,
  output logic                           tw_last,
  output logic                           busy,
  output logic                           err
);

  localparam int LGN = (NPT == NPT_DEF) ? LOG2N : $clog2(NPT);
  localparam int SW  = $clog2(LGN);
  localparam int KW  = LGN - 1;
  localparam logic [LGN-1:0] HALF      = (LGN)'(NPT / 2);
  localparam logic [LGN-1:0] ONE       = (LGN)'(1);
  localparam logic [SW-1:0]  TOP_STAGE = (SW)'(LGN - 1);
  localparam logic [SW:0]    NSTAGE    = (SW + 1)'(LGN);

  state_t         state_q;
  state_t         state_d;
  logic [SW-1:0]  stage_q;
  logic [LGN-1:0] j_q;
  logic           slot_free;
  logic           accept;
  logic           load;
  logic           done;
  logic           err_d;
  logic [LGN-1:0] j_sel;
  logic [SW-1:0]  stage_sel;
  logic [LGN-1:0] jmask;
  logic [SW-1:0]  shamt;
  logic [KW-1:0]  k_sel;

  assign slot_free = !tw_valid || tw_ready;
  assign busy      = (state_q == RUN);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and load decisions; an accepted start loads twiddle j=0 in the same edge
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    load      = 1'b0;
    done      = 1'b0;
    err_d     = 1'b0;
    j_sel     = j_q;
    stage_sel = stage_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if ({1'b0, stage} < NSTAGE) begin
            accept    = 1'b1;
            load      = 1'b1;
            state_d   = RUN;
            j_sel     = '0;
            stage_sel = stage;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (slot_free && (j_q < HALF)) load = 1'b1;
        if (tw_valid && tw_ready && tw_last) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Exponent of the twiddle being loaded: (j mod 2^stage) << (LGN-1-stage)
  always_comb begin
    jmask = (ONE << stage_sel) - ONE;
    shamt = TOP_STAGE - stage_sel;
    k_sel = (KW)'((j_sel & jmask) << shamt);
  end

  // Sequencer datapath: stage latch, butterfly counter and the tw_k/tw_last/tw_valid slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q  <= '0;
      j_q      <= '0;
      tw_valid <= 1'b0;
      tw_k     <= '0;
      tw_last  <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= err_d;
      if (accept) stage_q <= stage;
      if (load) begin
        j_q      <= j_sel + ONE;
        tw_k     <= k_sel;
        tw_last  <= (j_sel == (HALF - ONE));
        tw_valid <= 1'b1;
      end else if (done) begin
        tw_valid <= 1'b0;
        tw_last  <= 1'b0;
      end else if (tw_valid && tw_ready) begin
        tw_valid <= 1'b0;
      end
    end
  end

  twiddle_qrom #(
    .W   (W),
    .NPT (NPT)
  ) u_qrom (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .k    (k_sel),
    .re   (tw_re),
    .im   (tw_im)
  );

endmodule
